// File: rtl/seg_scan_mux.sv
// seg_scan_mux
//   Time-multiplexed scanner for an NDIG-digit common-anode 7-segment display.
//   One nibble at a time goes to the downstream hex decoder on dig. The matching
//   anode and decimal point are driven at the same time. Data and dp requests are
//   captured into a shadow copy once per frame, so a digit never tears mid-frame.
//   Leading zeros can optionally be blanked.
//
// Ports
//   clk    in   1       system clock, rising edge
//   rst    in   1       synchronous reset, active-high
//   en     in   1       display enable; 0 forces anodes/dp inactive, scan keeps running
//   lz_en  in   1       blank leading zero digits
//   data   in   4*NDIG  hex value, nibble 0 = rightmost digit
//   dp_in  in   NDIG    decimal point request per digit, 1 = lit
//   dig    out  4       nibble for the decoder (never inverted)
//   an     out  NDIG    one-hot anode enables, polarity per ACT_LOW
//   dp     out  1       decimal point, polarity per ACT_LOW
//   frame  out  1       one-cycle pulse on the edge the shadow reloads
module seg_scan_mux #(
    parameter int NDIG    = 4,
    parameter int DIV     = 50000,
    parameter int ACT_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              lz_en,
    input  logic [4*NDIG-1:0] data,
    input  logic [NDIG-1:0]   dp_in,
    output logic [3:0]        dig,
    output logic [NDIG-1:0]   an,
    output logic              dp,
    output logic              frame
);

    localparam int   PW    = $clog2(DIV);
    localparam int   IW    = $clog2(NDIG);
    // Level of an inactive anode/dp; XOR with it converts "active=1" to board polarity.
    localparam logic INACT = (ACT_LOW != 0);

    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] shd_data_q, shd_data_d;
    logic [NDIG-1:0]   shd_dp_q, shd_dp_d;
    logic [3:0]        dig_q, dig_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              dp_q, dp_d;
    logic              frame_q, frame_d;

    logic              tick;
    logic              wrap;
    logic [NDIG-1:0]   zabove;
    logic [NDIG-1:0]   onehot;
    logic [3:0]        nib;
    logic              sel_dp;
    logic              blank;

    always_comb begin
        tick   = (pcnt_q == PW'(DIV - 1));
        wrap   = tick && (idx_q == IW'(NDIG - 1));
        pcnt_d = tick ? '0 : pcnt_q + PW'(1);
        idx_d  = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end

        shd_data_d = wrap ? data  : shd_data_q;
        shd_dp_d   = wrap ? dp_in : shd_dp_q;
        frame_d    = wrap;

        // zabove[k]: nibbles NDIG-1..k of the (post-update) shadow are all zero.
        zabove = '0;
        zabove[NDIG-1] = (shd_data_d[4*(NDIG-1) +: 4] == 4'h0);
        for (int k = NDIG - 2; k >= 0; k--) begin
            zabove[k] = zabove[k+1] && (shd_data_d[4*k +: 4] == 4'h0);
        end

        nib    = 4'h0;
        sel_dp = 1'b0;
        blank  = 1'b0;
        onehot = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_d == IW'(k)) begin
                nib       = shd_data_d[4*k +: 4];
                sel_dp    = shd_dp_d[k];
                blank     = lz_en && (k != 0) && zabove[k];
                onehot[k] = 1'b1;
            end
        end

        dig_d = dig_q;
        an_d  = an_q;
        dp_d  = dp_q;
        if (tick) begin
            dig_d = nib;
            an_d  = blank ? {NDIG{INACT}} : (onehot ^ {NDIG{INACT}});
            dp_d  = blank ? INACT : (sel_dp ^ INACT);
        end
        // Disable overrides only the visible drive; the scan itself keeps its phase.
        if (!en) begin
            an_d = {NDIG{INACT}};
            dp_d = INACT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q     <= '0;
            idx_q      <= IW'(NDIG - 1);
            shd_data_q <= '0;
            shd_dp_q   <= '0;
            dig_q      <= 4'h0;
            an_q       <= {NDIG{INACT}};
            dp_q       <= INACT;
            frame_q    <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            idx_q      <= idx_d;
            shd_data_q <= shd_data_d;
            shd_dp_q   <= shd_dp_d;
            dig_q      <= dig_d;
            an_q       <= an_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
        end
    end

    assign dig   = dig_q;
    assign an    = an_q;
    assign dp    = dp_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with NDIG=4, DIV=4, ACT_LOW=1.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// Every scenario task ends just after the edge that enters slot 0 of a frame.
module tb_seg_scan_mux;

    logic        clk;
    logic        rst;
    logic        en;
    logic        lz_en;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  dig;
    logic [3:0]  an;
    logic        dp;
    logic        frame;

    int errors = 0;
    int checks = 0;

    seg_scan_mux #(.NDIG(4), .DIV(4), .ACT_LOW(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .lz_en (lz_en),
        .data  (data),
        .dp_in (dp_in),
        .dig   (dig),
        .an    (an),
        .dp    (dp),
        .frame (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; lz_en = 1'b0; data = 16'h1234; dp_in = 4'b0100;
        step(2);
        checks++;
        if ({an, dig, dp, frame} !== {4'b1111, 4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: an/dig/dp/frame got %b/%h/%b/%b want 1111/0/1/0", an, dig, dp, frame);
        end
        rst = 1'b0;
        step(3);
        checks++;
        if ({an, frame} !== {4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL reset_pre_tick: an/frame got %b/%b want 1111/0", an, frame);
        end
        step(1);
        checks++;
        if ({an, dig, dp, frame} !== {4'b1110, 4'h4, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_first_slot: an/dig/dp/frame got %b/%h/%b/%b want 1110/4/1/1", an, dig, dp, frame);
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] exp_dg [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        logic       exp_dp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({an, dig, dp, frame} !== {exp_an[i%4], exp_dg[i%4], exp_dp[i%4], (i % 4) == 0}) begin
                errors++;
                $display("FAIL scan_entry[%0d]: an/dig/dp/frame got %b/%h/%b/%b want %b/%h/%b/%b",
                         i, an, dig, dp, frame, exp_an[i%4], exp_dg[i%4], exp_dp[i%4], (i % 4) == 0);
            end
            step(3);
            checks++;
            if ({an, dig, dp, frame} !== {exp_an[i%4], exp_dg[i%4], exp_dp[i%4], 1'b0}) begin
                errors++;
                $display("FAIL scan_hold[%0d]: an/dig/dp/frame got %b/%h/%b/%b want %b/%h/%b/0",
                         i, an, dig, dp, frame, exp_an[i%4], exp_dg[i%4], exp_dp[i%4]);
            end
            step(1);
        end
    endtask

    task automatic test_coherency();
        logic [3:0] exp_dg [4] = '{4'hD, 4'hC, 4'hB, 4'hA};
        logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        int nframe = 0;
        step(8);
        data = 16'hABCD;
        step(4);
        checks++;
        if ({an, dig} !== {4'b0111, 4'h1}) begin
            errors++;
            $display("FAIL coh_old_slot3: an/dig got %b/%h want 0111/1", an, dig);
        end
        step(4);
        for (int j = 0; j < 16; j++) begin
            if (frame) nframe++;
            if (j % 4 == 0) begin
                checks++;
                if ({an, dig} !== {exp_an[j/4], exp_dg[j/4]}) begin
                    errors++;
                    $display("FAIL coh_new_slot[%0d]: an/dig got %b/%h want %b/%h",
                             j / 4, an, dig, exp_an[j/4], exp_dg[j/4]);
                end
            end
            step(1);
        end
        checks++;
        if (nframe !== 1) begin
            errors++;
            $display("FAIL coh_frame_count: got %0d pulses want 1 per 16 cycles", nframe);
        end
    endtask

    task automatic test_lz();
        data = 16'h0050; lz_en = 1'b1; dp_in = 4'b1000;
        step(16);
        checks++;
        if ({an, dig, dp} !== {4'b1110, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL lz_slot0: an/dig/dp got %b/%h/%b want 1110/0/1", an, dig, dp);
        end
        step(4);
        checks++;
        if ({an, dig} !== {4'b1101, 4'h5}) begin
            errors++;
            $display("FAIL lz_slot1: an/dig got %b/%h want 1101/5", an, dig);
        end
        step(4);
        checks++;
        if ({an, dig, dp} !== {4'b1111, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL lz_slot2: an/dig/dp got %b/%h/%b want 1111/0/1", an, dig, dp);
        end
        step(4);
        checks++;
        if ({an, dig, dp} !== {4'b1111, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL lz_slot3_dp: an/dig/dp got %b/%h/%b want 1111/0/1", an, dig, dp);
        end
        data = 16'h0000; dp_in = 4'b0000;
        for (int s = 0; s < 5; s++) begin
            step(4);
            checks++;
            if ({an, dig} !== {((s % 4) == 0) ? 4'b1110 : 4'b1111, 4'h0}) begin
                errors++;
                $display("FAIL lz_zero_slot[%0d]: an/dig got %b/%h want %b/0",
                         s % 4, an, dig, ((s % 4) == 0) ? 4'b1110 : 4'b1111);
            end
        end
        lz_en = 1'b0; data = 16'h1234; dp_in = 4'b0100;
        step(16);
        checks++;
        if ({an, dig, frame} !== {4'b1110, 4'h4, 1'b1}) begin
            errors++;
            $display("FAIL lz_restore: an/dig/frame got %b/%h/%b want 1110/4/1", an, dig, frame);
        end
    endtask

    task automatic test_enable();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if ({an, dp} !== {4'b1111, 1'b1}) begin
                errors++;
                $display("FAIL en_off[%0d]: an/dp got %b/%b want 1111/1", i, an, dp);
            end
        end
        checks++;
        if (dig !== 4'h2) begin
            errors++;
            $display("FAIL en_off_scan: dig got %h want 2", dig);
        end
        en = 1'b1;
        step(1);
        checks++;
        if (an !== 4'b1111) begin
            errors++;
            $display("FAIL en_midslot: an got %b want 1111", an);
        end
        step(1);
        checks++;
        if ({an, dig} !== {4'b0111, 4'h1}) begin
            errors++;
            $display("FAIL en_resume: an/dig got %b/%h want 0111/1", an, dig);
        end
        step(4);
        checks++;
        if ({an, dig, frame} !== {4'b1110, 4'h4, 1'b1}) begin
            errors++;
            $display("FAIL en_wrap: an/dig/frame got %b/%h/%b want 1110/4/1", an, dig, frame);
        end
    endtask

    task automatic test_reset_mid();
        step(9);
        rst = 1'b1;
        step(1);
        checks++;
        if ({an, dig, dp, frame} !== {4'b1111, 4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_state: an/dig/dp/frame got %b/%h/%b/%b want 1111/0/1/0", an, dig, dp, frame);
        end
        rst = 1'b0;
        step(3);
        checks++;
        if (an !== 4'b1111) begin
            errors++;
            $display("FAIL rstmid_pre_tick: an got %b want 1111", an);
        end
        step(1);
        checks++;
        if ({an, dig, dp, frame} !== {4'b1110, 4'h4, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_restart: an/dig/dp/frame got %b/%h/%b/%b want 1110/4/1/1", an, dig, dp, frame);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; lz_en = 1'b0; data = '0; dp_in = '0;
        test_reset();
        test_scan();
        test_coherency();
        test_lz();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
